ir_queue: RTL and testbench
===========================

# ir_queue

Parametrised instruction register with a small prefetch queue, replacing the single-slot combinational instruction register between instruction memory and the controller. It accepts instructions from the fetch side over a valid/ready handshake and buffers up to DEPTH of them. It presents the oldest instruction to the controller, split into opcode and immediate fields, with the immediate optionally sign-extended. A flush input discards all buffered instructions on jumps and branches.

## Interface
- INSTR_W, 8, instruction width in bits
- IMM_W, 4, width of immediate field, taken from instruction bits [IMM_W-1:0]; 1 <= IMM_W < INSTR_W
- DATA_W, 8, width of the extended immediate output; DATA_W >= IMM_W
- DEPTH, 4, queue entries; power of two, >= 2
- SIGN_EXT, 0, 0 = zero-extend immediate, 1 = sign-extend
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  fetch side presents an instruction
- in_instr  input  INSTR_W  instruction from memory
- in_ready  output  1  queue can accept (count < DEPTH)
- flush  input  1  discard all queued instructions
- out_valid  output  1  head entry valid (count != 0)
- out_ready  input  1  controller consumes head this cycle
- ir_out  output  INSTR_W  head instruction; zero when empty
- opcode  output  INSTR_W-IMM_W  ir_out[INSTR_W-1:IMM_W]
- immediate  output  DATA_W  ir_out[IMM_W-1:0] extended per SIGN_EXT
- count  output  clog2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH x INSTR_W register array, write pointer wp, read pointer rp (each clog2(DEPTH) bits, natural wrap), occupancy counter count.
- Push = in_valid & in_ready: write in_instr at wp, wp+1.
- Pop = out_valid & out_ready: rp+1.
- Count update: push only +1; pop only -1; both unchanged.
- in_ready depends only on count (count < DEPTH), never on out_ready: there is no pass-through when full.
- Push and pop in the same cycle with 0 < count < DEPTH: both proceed.
- Pop with out_valid low is ignored; push with in_ready low is ignored and the entry is not written.
- Flush has priority over push and pop. In the flush cycle: wp, rp and count go to 0, and any same-cycle push or pop is discarded.
- Reset behaves identically to flush, and also clears the storage array to 0.
- Output fields are combinational from the head register rp and count. ir_out, opcode and immediate are all-zero whenever count == 0.
- Immediate extension fills bits [DATA_W-1:IMM_W]:
  - with ir_out[IMM_W-1] when SIGN_EXT = 1;
  - with 0 otherwise.
  - When DATA_W == IMM_W, no extension.

## Timing
- Reset values: in_ready = 1, out_valid = 0, ir_out = 0, opcode = 0, immediate = 0, count = 0.
- Latency: an instruction pushed at edge N appears on ir_out with out_valid = 1 after edge N (next cycle), provided it is at the head.
- Throughput: one push and one pop per cycle sustained.
- Full: count == DEPTH gives in_ready = 0 in the same cycle. A pop at full raises in_ready the cycle after.
- Empty: count == 0 gives out_valid = 0. A push into an empty queue with out_ready held high is popped in the following cycle, not the same one.
- Pointer wrap: after DEPTH pushes, wp returns to 0; ordering must be preserved across the wrap.
- Flush or reset asserted mid-stream: outputs read empty from the next cycle; in_ready = 1 from the next cycle.
- flush and rst held for multiple cycles: the queue stays empty and all pushes are dropped.

## Test plan
- Reset then idle: assert rst 2 cycles -> count = 0, out_valid = 0, in_ready = 1, ir_out = 0x00, immediate = 0x00.
- Fill and drain (DEPTH = 4): push 0xA1, 0xB2, 0xC3, 0xD4 with out_ready = 0 -> count = 4, in_ready = 0, and a fifth push of 0xE5 is dropped. Then out_ready = 1 -> ir_out sequence A1, B2, C3, D4, then out_valid = 0.
- Simultaneous push/pop with wrap: keep count = 2 while streaming 10 instructions 0x10..0x19 with push and pop every cycle -> output order is exactly 0x10..0x19 and count stays 2.
- Immediate extension (SIGN_EXT = 1, IMM_W = 4, DATA_W = 8):
  - head 0x3C -> opcode = 0x3, immediate = 0xFC.
  - head 0x35 -> immediate = 0x05.
  - With SIGN_EXT = 0, head 0x3C -> immediate = 0x0C.
- Flush priority: with count = 3, assert flush together with in_valid (0x77) and out_ready -> next cycle count = 0, out_valid = 0, and 0x77 never appears on ir_out.
- Full boundary: at count = 4, pop one entry -> in_ready = 1 the following cycle. Then push 0x99 -> it appears on ir_out after the three older entries.

Source files
------------

// File: rtl/ir_queue.sv
// ir_queue: instruction register fronted by a small prefetch queue.
//
// Buffers up to DEPTH instructions from the fetch side (valid/ready) and
// presents the oldest one to the controller. The head is shown whole on
// ir_out and also split into an opcode field and an immediate field. The
// immediate is zero- or sign-extended to DATA_W. A flush drops every
// buffered instruction when the program counter is redirected.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (flush + clear storage)
//   in_valid   fetch side presents in_instr
//   in_instr   instruction from memory
//   in_ready   queue can accept (count < DEPTH)
//   flush      discard all queued instructions
//   out_valid  head entry valid (count != 0)
//   out_ready  controller consumes the head this cycle
//   ir_out     head instruction, zero when empty
//   opcode     ir_out[INSTR_W-1:IMM_W]
//   immediate  ir_out[IMM_W-1:0] extended to DATA_W
//   count      number of valid entries
module ir_queue #(
  parameter int INSTR_W  = 8,
  parameter int IMM_W    = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int SIGN_EXT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         ir_out,
  output logic [INSTR_W-IMM_W-1:0]   opcode,
  output logic [DATA_W-1:0]          immediate,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wp;
  logic [AW-1:0]      rp;
  logic [CW-1:0]      cnt;
  logic               push;
  logic               pop;
  logic [IMM_W-1:0]   imm;

  // in_ready is a function of occupancy alone, so a full queue never accepts
  // even when the head is being consumed in the same cycle.
  assign in_ready  = (cnt < CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= in_instr;
        wp      <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Stale storage is masked so every output field reads zero when empty.
  always_comb begin
    ir_out = '0;
    if (cnt != '0) begin
      ir_out = mem[rp];
    end
  end

  assign opcode = ir_out[INSTR_W-1:IMM_W];
  assign imm    = ir_out[IMM_W-1:0];

  generate
    if (DATA_W > IMM_W) begin : g_ext
      logic fill;
      assign fill      = (SIGN_EXT != 0) ? imm[IMM_W-1] : 1'b0;
      assign immediate = {{(DATA_W-IMM_W){fill}}, imm};
    end else begin : g_noext
      assign immediate = imm;
    end
  endgenerate

endmodule

// File: tb/tb_ir_queue.sv
module tb_ir_queue;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_instr;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ir_out;
  logic [3:0] opcode;
  logic [7:0] immediate;
  logic [2:0] count;

  // zero-extending twin sharing the same stimulus
  logic       in_ready_z;
  logic       out_valid_z;
  logic [7:0] ir_out_z;
  logic [3:0] opcode_z;
  logic [7:0] immediate_z;
  logic [2:0] count_z;

  int n_checks;
  int n_fail;

  ir_queue #(.INSTR_W(8), .IMM_W(4), .DATA_W(8), .DEPTH(4), .SIGN_EXT(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .ir_out(ir_out), .opcode(opcode),
    .immediate(immediate), .count(count)
  );

  ir_queue #(.INSTR_W(8), .IMM_W(4), .DATA_W(8), .DEPTH(4), .SIGN_EXT(0)) u_dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready_z), .flush(flush), .out_valid(out_valid_z),
    .out_ready(out_ready), .ir_out(ir_out_z), .opcode(opcode_z),
    .immediate(immediate_z), .count(count_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 8'h00; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (ir_out !== 8'h00) begin n_fail++; $display("FAIL reset_ir_out: got %h expected 00", ir_out); end
    n_checks++; if (immediate !== 8'h00) begin n_fail++; $display("FAIL reset_immediate: got %h expected 00", immediate); end
    n_checks++; if (opcode !== 4'h0) begin n_fail++; $display("FAIL reset_opcode: got %h expected 0", opcode); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3; vals[3] = 8'hD4;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = vals[i];
      step();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    in_instr = 8'hE5;
    step();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL drop_count: got %0d expected 4", count); end
    n_checks++; if (ir_out !== 8'hA1) begin n_fail++; $display("FAIL drop_head: got %h expected a1", ir_out); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b1 || ir_out !== vals[i]) begin
        n_fail++; $display("FAIL drain_%0d: got valid=%b ir=%h expected valid=1 ir=%h", i, out_valid, ir_out, vals[i]);
      end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || ir_out !== 8'h00) begin
      n_fail++; $display("FAIL drain_empty: got valid=%b ir=%h expected valid=0 ir=00", out_valid, ir_out);
    end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 8'h5A;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pre_valid: got %b expected 0", out_valid); end
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || ir_out !== 8'h5A || count !== 3'd1) begin
      n_fail++; $display("FAIL lat_visible: got valid=%b ir=%h cnt=%0d expected valid=1 ir=5a cnt=1", out_valid, ir_out, count);
    end
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL lat_popped: got valid=%b cnt=%0d expected valid=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 8'h10; step();
    in_instr  = 8'h11; step();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_instr = 8'h12 + 8'(i);
      exp      = 8'h10 + 8'(i);
      n_checks++; if (ir_out !== exp || count !== 3'd2) begin
        n_fail++; $display("FAIL stream_%0d: got ir=%h cnt=%0d expected ir=%h cnt=2", i, ir_out, count, exp);
      end
      step();
    end
    in_valid = 1'b0;
    for (int i = 8; i < 10; i++) begin
      exp = 8'h10 + 8'(i);
      n_checks++; if (ir_out !== exp || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stream_%0d: got ir=%h valid=%b expected ir=%h valid=1", i, ir_out, out_valid, exp);
      end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_immediate();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 8'h3C; step();
    in_instr  = 8'h35; step();
    in_valid  = 1'b0;
    n_checks++; if (opcode !== 4'h3) begin n_fail++; $display("FAIL imm_opcode: got %h expected 3", opcode); end
    n_checks++; if (immediate !== 8'hFC) begin n_fail++; $display("FAIL imm_sext_neg: got %h expected fc", immediate); end
    n_checks++; if (immediate_z !== 8'h0C) begin n_fail++; $display("FAIL imm_zext: got %h expected 0c", immediate_z); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (immediate !== 8'h05) begin n_fail++; $display("FAIL imm_sext_pos: got %h expected 05", immediate); end
    n_checks++; if (immediate_z !== 8'h05) begin n_fail++; $display("FAIL imm_zext_pos: got %h expected 05", immediate_z); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 8'h21; step();
    in_instr  = 8'h22; step();
    in_instr  = 8'h23; step();
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    flush     = 1'b1;
    in_instr  = 8'h77;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ir_out !== 8'h00) begin
      n_fail++; $display("FAIL flush_empty: got cnt=%0d valid=%b rdy=%b ir=%h expected cnt=0 valid=0 rdy=1 ir=00", count, out_valid, in_ready, ir_out);
    end
    // held flush drops every push
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (count !== 3'd0 || ir_out !== 8'h00) begin
        n_fail++; $display("FAIL flush_hold_%0d: got cnt=%0d ir=%h expected cnt=0 ir=00", i, count, ir_out);
      end
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    n_checks++; if (count !== 3'd0 || ir_out !== 8'h00) begin
      n_fail++; $display("FAIL flush_after: got cnt=%0d ir=%h expected cnt=0 ir=00", count, ir_out);
    end
  endtask

  task automatic test_full_boundary();
    logic [7:0] exp [4];
    exp[0] = 8'h42; exp[1] = 8'h43; exp[2] = 8'h44; exp[3] = 8'h99;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = 8'h41 + 8'(i);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_passthru: got %b expected 0", in_ready); end
    step();
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || count !== 3'd3) begin
      n_fail++; $display("FAIL full_pop_ready: got rdy=%b cnt=%0d expected rdy=1 cnt=3", in_ready, count);
    end
    in_valid = 1'b1;
    in_instr = 8'h99;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b1 || ir_out !== exp[i]) begin
        n_fail++; $display("FAIL full_order_%0d: got valid=%b ir=%h expected valid=1 ir=%h", i, out_valid, ir_out, exp[i]);
      end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_final_empty: got valid=%b rdy=%b expected valid=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 8'h61; step();
    in_instr  = 8'h62; step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ir_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid: got cnt=%0d valid=%b rdy=%b ir=%h expected cnt=0 valid=0 rdy=1 ir=00", count, out_valid, in_ready, ir_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 8'h00; out_ready = 1'b0;
    #1;
    test_reset();
    test_fill_drain();
    test_latency();
    test_back_to_back();
    test_immediate();
    test_flush();
    test_full_boundary();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
